// File: rtl/popcount_rr_scheduler.sv
// popcount_rr_scheduler: round-robin shares one pipelined popcount unit among N_REQ requesters
// and routes each count back with the ID of the requester that issued it.
module popcount_rr_scheduler #(
  parameter int WIDTH      = 8,
  parameter int N_REQ      = 4,
  parameter int PC_LATENCY = 4
) (
  input  logic                               clk_i,
  input  logic                               arst_n_i,
  input  logic [N_REQ-1:0]                   req_val_i,
  input  logic [N_REQ-1:0][WIDTH-1:0]        req_data_i,
  output logic [N_REQ-1:0]                   req_ready_o,
  output logic                               pc_srst_o,
  output logic [WIDTH-1:0]                   pc_data_o,
  output logic                               pc_data_val_o,
  input  logic [$clog2(WIDTH):0]             pc_data_i,
  input  logic                               pc_data_val_i,
  output logic [$clog2(WIDTH):0]             res_data_o,
  output logic [$clog2(N_REQ)-1:0]           res_id_o,
  output logic                               res_val_o,
  output logic                               busy_o,
  output logic                               err_o
);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int IDW = $clog2(N_REQ);
  localparam int FCW = $clog2(PC_LATENCY + 2);
  localparam logic ST_FLUSH = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  logic                           r_state;
  logic [FCW-1:0]                 r_flush_cnt;
  logic [IDW-1:0]                 r_ptr;
  logic [WIDTH-1:0]               r_pc_data;
  logic                           r_pc_val;
  logic [IDW-1:0]                 r_pc_id;
  logic [PC_LATENCY-1:0]          r_tag_val;
  logic [PC_LATENCY-1:0][IDW-1:0] r_tag_id;
  logic [CW-1:0]                  r_res_data;
  logic [IDW-1:0]                 r_res_id;
  logic                           r_res_val;
  logic                           r_err;
  logic                           w_run;
  logic                           w_xfer;
  logic                           w_tail_val;
  logic                           w_hit;
  logic [IDW-1:0]                 w_tail_id;
  logic [IDW-1:0]                 w_gid;
  logic [IDW-1:0]                 w_cand;

  // Scan from farthest to nearest so the nearest requester after r_ptr wins.
  always_comb begin
    w_gid  = '0;
    w_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = IDW'((int'(r_ptr) + k) % N_REQ);
      if (req_val_i[w_cand]) w_gid = w_cand;
    end
  end

  assign w_run       = r_state == ST_RUN;
  assign w_xfer      = w_run & (|req_val_i);
  assign req_ready_o = w_xfer ? N_REQ'(1) << w_gid : '0;
  assign w_tail_val  = r_tag_val[PC_LATENCY-1];
  assign w_tail_id   = r_tag_id[PC_LATENCY-1];
  assign w_hit       = w_run & w_tail_val & pc_data_val_i;

  assign pc_srst_o     = ~w_run;
  assign pc_data_o     = r_pc_data;
  assign pc_data_val_o = r_pc_val;
  assign res_data_o    = r_res_data;
  assign res_id_o      = r_res_id;
  assign res_val_o     = r_res_val;
  assign err_o         = r_err;
  assign busy_o        = ~w_run | (|r_tag_val) | r_pc_val;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= '0;
      r_ptr       <= IDW'(N_REQ - 1);
      r_pc_data   <= '0;
      r_pc_val    <= 1'b0;
      r_pc_id     <= '0;
      r_tag_val   <= '0;
      r_tag_id    <= '0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_val   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (!w_run) r_flush_cnt <= r_flush_cnt + FCW'(1);
      if (!w_run && r_flush_cnt == FCW'(PC_LATENCY)) r_state <= ST_RUN;
      r_pc_val <= w_xfer;
      if (w_xfer) begin
        r_pc_data <= req_data_i[w_gid];
        r_pc_id   <= w_gid;
        r_ptr     <= w_gid;
      end
      r_tag_val <= {r_tag_val[PC_LATENCY-2:0], r_pc_val};
      r_tag_id  <= {r_tag_id[PC_LATENCY-2:0], r_pc_id};
      r_res_val <= w_hit;
      if (w_hit) begin
        r_res_data <= pc_data_i;
        r_res_id   <= w_tail_id;
      end
      if (w_run && (w_tail_val != pc_data_val_i)) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_popcount_rr_scheduler.sv
// tb_popcount_rr_scheduler: table, hand sequences and random traffic against a queue-based model,
// with a behavioural 4-cycle popcount unit that can drop or invent valids.
module tb_popcount_rr_scheduler;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int CW = 4;

  typedef struct {logic [N-1:0] val; logic [N-1:0] rdy; int cnt;} vec_t;
  typedef struct {int id; int cnt; int due;} exp_t;

  logic                clk = 1'b0;
  logic                arst_n = 1'b0;
  logic [N-1:0]        req_val = '0;
  logic [N-1:0][W-1:0] req_data = '0;
  logic [N-1:0]        req_ready_o;
  logic                pc_srst_o, pc_data_val_o, pc_data_val_i;
  logic [W-1:0]        pc_data_o;
  logic [CW-1:0]       pc_data_i, res_data_o;
  logic [1:0]          res_id_o;
  logic                res_val_o, busy_o, err_o;
  logic                drop = 1'b0, spur = 1'b0, seen = 1'b0;
  logic [CW-1:0]       cp_d [L];
  logic [L-1:0]        cp_v;
  int                  checks = 0, fails = 0, cyc = 0;
  bit                  mon_en = 1'b0;
  exp_t                q[$];
  vec_t                tbl[18];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  popcount_rr_scheduler #(.WIDTH(W), .N_REQ(N), .PC_LATENCY(L)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .req_val_i(req_val), .req_data_i(req_data),
    .req_ready_o(req_ready_o), .pc_srst_o(pc_srst_o), .pc_data_o(pc_data_o),
    .pc_data_val_o(pc_data_val_o), .pc_data_i(pc_data_i), .pc_data_val_i(pc_data_val_i),
    .res_data_o(res_data_o), .res_id_o(res_id_o), .res_val_o(res_val_o),
    .busy_o(busy_o), .err_o(err_o));

  // Stand-in for the shared counter: fixed latency, sync reset, fault injection hooks.
  always @(posedge clk) begin
    if (pc_srst_o) begin
      cp_v <= '0;
      for (int i = 0; i < L; i++) cp_d[i] <= '0;
    end else begin
      cp_v     <= {cp_v[L-2:0], pc_data_val_o};
      cp_d[0]  <= CW'($countones(pc_data_o));
      for (int i = 1; i < L; i++) cp_d[i] <= cp_d[i-1];
    end
  end
  assign pc_data_i     = cp_d[L-1];
  assign pc_data_val_i = (cp_v[L-1] & ~drop) | spur;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("res_val", res_val_o, 1);
      chk("res_id", res_id_o, q[0].id);
      chk("res_data", res_data_o, q[0].cnt);
      void'(q.pop_front());
    end else chk("res_idle", res_val_o, 0);
  end

  // Called at a negedge; the transfer, if any, happens on the next posedge.
  task automatic drive(logic [N-1:0] v, logic [N-1:0] exp_rdy, int cnt, string nm);
    int id = 0;
    req_val = v;
    #1;
    chk(nm, req_ready_o, exp_rdy);
    for (int i = 0; i < N; i++) if (exp_rdy[i]) id = i;
    if (exp_rdy != 0) q.push_back('{id: id, cnt: cnt, due: cyc + L + 2});
    @(negedge clk);
  endtask

  task automatic drain();
    req_val = '0;
    for (int i = 0; i < 30 && (q.size() > 0 || busy_o); i++) @(negedge clk);
    chk("drain_idle", int'(busy_o) + q.size(), 0);
  endtask

  task automatic do_reset();
    arst_n  = 1'b0;
    req_val = '0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (L + 1) @(negedge clk);
  endtask

  initial begin
    int ptr, g;
    logic [N-1:0] pend, rdy;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ptr, g;
    logic [N-1:0] pend, rdy;
    tbl[0]  = '{4'b1111, 4'b0001, 8};
    tbl[1]  = '{4'b1111, 4'b0010, 3};
    tbl[2]  = '{4'b1111, 4'b0100, 5};
    tbl[3]  = '{4'b1111, 4'b1000, 2};
    tbl[4]  = '{4'b1111, 4'b0001, 8};
    tbl[5]  = '{4'b1111, 4'b0010, 3};
    tbl[6]  = '{4'b1111, 4'b0100, 5};
    tbl[7]  = '{4'b1111, 4'b1000, 2};
    tbl[8]  = '{4'b1010, 4'b0010, 3};
    tbl[9]  = '{4'b1010, 4'b1000, 2};
    tbl[10] = '{4'b1010, 4'b0010, 3};
    tbl[11] = '{4'b1011, 4'b1000, 2};
    tbl[12] = '{4'b1011, 4'b0001, 8};
    tbl[13] = '{4'b1011, 4'b0010, 3};
    tbl[14] = '{4'b1001, 4'b1000, 2};
    tbl[15] = '{4'b0001, 4'b0001, 8};
    tbl[16] = '{4'b0000, 4'b0000, 0};
    tbl[17] = '{4'b0100, 4'b0100, 5};
    req_data = {8'h81, 8'hB5, 8'h07, 8'hFF};
    req_val  = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_srst", pc_srst_o, 1);
    chk("rst_pc_val", pc_data_val_o, 0);
    chk("rst_pc_data", pc_data_o, 0);
    chk("rst_res_val", res_val_o, 0);
    chk("rst_res_data", res_data_o, 0);
    chk("rst_res_id", res_id_o, 0);
    chk("rst_busy", busy_o, 1);
    chk("rst_err", err_o, 0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < L + 1; i++) begin
      #1;
      chk("flush_ready", req_ready_o, 0);
      chk("flush_srst", pc_srst_o, 1);
      @(negedge clk);
    end
    mon_en = 1'b1;
    for (int i = 0; i < 18; i++) drive(tbl[i].val, tbl[i].rdy, tbl[i].cnt, "tbl_ready");
    drain();
    chk("run_srst", pc_srst_o, 0);
    drive(4'b0100, 4'b0100, 5, "single_ready");
    drain();
    // Random traffic: requesters hold until granted; model arbitrates by rotating priority.
    do_reset();
    ptr  = N - 1;
    pend = '0;
    repeat (200) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]     = 1'b1;
          req_data[i] = W'($urandom);
        end
      g = -1;
      for (int k = 1; k <= N; k++) if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
      rdy = (g < 0) ? '0 : N'(1 << g);
      drive(pend, rdy, (g < 0) ? 0 : $countones(req_data[g]), "rand_ready");
      if (g >= 0) begin
        ptr     = g;
        pend[g] = 1'b0;
      end
    end
    drain();
    mon_en = 1'b0;
    chk("err_clean", err_o, 0);
    drop = 1'b1;
    drive(4'b0010, 4'b0010, 3, "err_issue");
    q.delete();
    req_val = '0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= res_val_o;
    end
    drop = 1'b0;
    chk("drop_no_res", seen, 0);
    chk("drop_err", err_o, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err_o, 1);
    do_reset();
    chk("err_cleared", err_o, 0);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    chk("spur_err", err_o, 1);
    chk("spur_no_res", res_val_o, 0);
    do_reset();
    drive(4'b0111, 4'b0001, 8, "inflight_g0");
    drive(4'b0110, 4'b0010, 3, "inflight_g1");
    drive(4'b0100, 4'b0100, 5, "inflight_g2");
    req_val = '0;
    @(negedge clk);
    q.delete();
    chk("inflight_busy", busy_o, 1);
    arst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready_o, 0);
    chk("arst_srst", pc_srst_o, 1);
    chk("arst_pc_val", pc_data_val_o, 0);
    chk("arst_pc_data", pc_data_o, 0);
    chk("arst_res_val", res_val_o, 0);
    chk("arst_busy", busy_o, 1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= res_val_o | err_o;
    end
    chk("arst_no_stale", seen, 0);
    chk("arst_idle", busy_o, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
